// File: rtl/flash_page_packer.sv
// flash_page_packer: splits one write request into page-aligned program operations
// of at most 256 bytes, buffering each chunk locally before issuing it to flash_driver.
module flash_page_packer #(
    parameter logic [1:0] P_PROGRAM_TYPE = 2'd1,
    parameter int         P_PAGE_SIZE    = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_req_addr,
    input  logic [15:0] i_req_len,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic [1:0]  o_operation_type,
    output logic [23:0] o_operation_addr,
    output logic [8:0]  o_operation_num,
    output logic        o_operation_valid,
    input  logic        i_operation_ready,
    output logic [7:0]  o_write_data,
    output logic        o_write_sop,
    output logic        o_write_eop,
    output logic        o_write_valid,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CMD, S_SEND} state_t;

    state_t      state_q;
    logic [23:0] addr_q;
    logic [15:0] rem_q;
    logic [8:0]  idx_q;
    logic [7:0]  page_mem_q [0:255];

    logic [1:0]  op_type_q;
    logic [23:0] op_addr_q;
    logic [8:0]  op_num_q;
    logic        op_valid_q;
    logic [7:0]  wr_data_q;
    logic        wr_sop_q;
    logic        wr_eop_q;
    logic        wr_valid_q;
    logic        busy_q;
    logic        done_q;

    logic [8:0]  space_w;
    logic [8:0]  clen_w;
    logic [8:0]  last_idx_w;
    logic        fill_beat_w;

    // addr_q and rem_q only move after a chunk is sent, so the chunk length can be
    // derived combinationally and stays stable through FILL, CMD and SEND.
    assign space_w     = 9'(P_PAGE_SIZE) - {1'b0, addr_q[7:0]};
    assign clen_w      = ({1'b0, rem_q} < {8'd0, space_w}) ? rem_q[8:0] : space_w;
    assign last_idx_w  = clen_w - 9'd1;
    assign fill_beat_w = (state_q == S_FILL) && i_s_valid;

    assign o_req_ready       = (state_q == S_IDLE);
    assign o_s_ready         = (state_q == S_FILL);
    assign o_operation_type  = op_type_q;
    assign o_operation_addr  = op_addr_q;
    assign o_operation_num   = op_num_q;
    assign o_operation_valid = op_valid_q;
    assign o_write_data      = wr_data_q;
    assign o_write_sop       = wr_sop_q;
    assign o_write_eop       = wr_eop_q;
    assign o_write_valid     = wr_valid_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;

    always_ff @(posedge i_clk) begin
        if (fill_beat_w) begin
            page_mem_q[idx_q[7:0]] <= i_s_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 24'd0;
            rem_q      <= 16'd0;
            idx_q      <= 9'd0;
            op_type_q  <= 2'd0;
            op_addr_q  <= 24'd0;
            op_num_q   <= 9'd0;
            op_valid_q <= 1'b0;
            wr_data_q  <= 8'd0;
            wr_sop_q   <= 1'b0;
            wr_eop_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid) begin
                        addr_q <= i_req_addr;
                        rem_q  <= i_req_len;
                        idx_q  <= 9'd0;
                        if (i_req_len == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (i_s_valid) begin
                        if (idx_q == last_idx_w) begin
                            idx_q      <= 9'd0;
                            state_q    <= S_CMD;
                            op_type_q  <= P_PROGRAM_TYPE;
                            op_addr_q  <= addr_q;
                            op_num_q   <= clen_w;
                            op_valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 9'd1;
                        end
                    end
                end
                S_CMD: begin
                    // Byte 0 is fetched during the handshake so the burst starts without a gap.
                    if (i_operation_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_SEND;
                        wr_data_q  <= page_mem_q[8'd0];
                        wr_sop_q   <= 1'b1;
                        wr_eop_q   <= (clen_w == 9'd1);
                        wr_valid_q <= 1'b1;
                        idx_q      <= 9'd1;
                    end
                end
                S_SEND: begin
                    if (wr_eop_q) begin
                        wr_valid_q <= 1'b0;
                        wr_sop_q   <= 1'b0;
                        wr_eop_q   <= 1'b0;
                        idx_q      <= 9'd0;
                        addr_q     <= addr_q + {15'd0, clen_w};
                        rem_q      <= rem_q - {7'd0, clen_w};
                        if (rem_q == {7'd0, clen_w}) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end else begin
                        wr_data_q <= page_mem_q[idx_q[7:0]];
                        wr_sop_q  <= 1'b0;
                        wr_eop_q  <= (idx_q == last_idx_w);
                        idx_q     <= idx_q + 9'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_page_packer.sv
// Testbench for flash_page_packer: random source data and handshake timing checked
// against a chunk-splitting reference model built from address/length arithmetic.
module tb_flash_page_packer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [23:0] i_req_addr = 24'd0;
    logic [15:0] i_req_len = 16'd0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [7:0]  i_s_data = 8'd0;
    logic        i_s_valid = 1'b0;
    logic        o_s_ready;
    logic [1:0]  o_operation_type;
    logic [23:0] o_operation_addr;
    logic [8:0]  o_operation_num;
    logic        o_operation_valid;
    logic        i_operation_ready = 1'b0;
    logic [7:0]  o_write_data;
    logic        o_write_sop;
    logic        o_write_eop;
    logic        o_write_valid;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int           expA[$];
    int           expN[$];
    byte unsigned srcQ[$];
    logic [34:0]  ops[$];
    logic [25:0]  beats[$];

    flash_page_packer dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_req_addr        (i_req_addr),
        .i_req_len         (i_req_len),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_s_data          (i_s_data),
        .i_s_valid         (i_s_valid),
        .o_s_ready         (o_s_ready),
        .o_operation_type  (o_operation_type),
        .o_operation_addr  (o_operation_addr),
        .o_operation_num   (o_operation_num),
        .o_operation_valid (o_operation_valid),
        .i_operation_ready (i_operation_ready),
        .o_write_data      (o_write_data),
        .o_write_sop       (o_write_sop),
        .o_write_eop       (o_write_eop),
        .o_write_valid     (o_write_valid),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_op_valid"}, o_operation_valid, 0);
        checkOutput({tag, "_op_fields"}, {o_operation_type, o_operation_addr, o_operation_num}, 0);
        checkOutput({tag, "_wr_flags"}, {o_write_valid, o_write_sop, o_write_eop}, 0);
        checkOutput({tag, "_wr_data"}, o_write_data, 0);
        checkOutput({tag, "_busy_done"}, {o_busy, o_done}, 0);
        checkOutput({tag, "_req_ready"}, o_req_ready, 1);
        checkOutput({tag, "_s_ready"}, o_s_ready, 0);
    endtask

    // One full request: build the expected chunk list and byte stream, drive the
    // source and operation handshake randomly, and compare what comes out.
    task automatic applyStimulus(input logic [23:0] addr, input int len, input int gapPct,
                                 input int stall, input int resetBeat);
        int a, r, n, srcIdx, nextB, opWait, tAcc, expOpCyc, expSrdyCyc, hsCyc;
        int lastEopCyc, doneCnt, doneCyc, eopCnt, pos;
        int bounds[$];
        logic [34:0] curOp;
        bit aborted;

        $display("[TB] request addr=0x%06h len=%0d", addr, len);
        expA.delete(); expN.delete(); srcQ.delete(); ops.delete(); beats.delete();
        a = int'(addr);
        r = len;
        while (r > 0) begin
            n = 256 - (a % 256);
            if (r < n) n = r;
            expA.push_back(a);
            expN.push_back(n);
            bounds.push_back(len - r + n);
            a = (a + n) % 16777216;
            r -= n;
        end
        for (int i = 0; i < len; i++) srcQ.push_back(8'($urandom));

        @(negedge i_clk); cyc++;
        checkOutput("req_ready_idle", o_req_ready, 1);
        i_req_addr = addr;
        i_req_len = 16'(len);
        i_req_valid = 1'b1;
        i_s_valid = 1'b0;
        i_operation_ready = 1'b0;
        tAcc = cyc;
        srcIdx = 0; nextB = 0; opWait = 0; expOpCyc = -1; expSrdyCyc = -1;
        hsCyc = -1000; lastEopCyc = -1; doneCnt = 0; doneCyc = -1; eopCnt = 0;
        aborted = 0; curOp = '0;

        forever begin
            @(negedge i_clk); cyc++;
            if (cyc - tAcc > 5000) begin
                checks++;
                failures++;
                $error("[TB] FAIL timeout observed=no_done expected=done_within_5000_cycles");
                break;
            end
            if (cyc == tAcc + 1) begin
                checkOutput("busy_after_accept", o_busy, len != 0);
                checkOutput("s_ready_after_accept", o_s_ready, len != 0);
            end
            if (cyc == expOpCyc) checkOutput("op_valid_after_fill", o_operation_valid, 1);
            if (cyc == expSrdyCyc) checkOutput("s_ready_next_chunk", o_s_ready, 1);
            if (o_write_valid && resetBeat >= 0 && (cyc - hsCyc - 1) == resetBeat) begin
                i_rst = 1'b0;
                #1;
                checkIdleOutputs("mid_send_reset");
                aborted = 1;
                break;
            end
            if (o_write_valid) begin
                beats.push_back({o_write_data, o_write_sop, o_write_eop, 16'(cyc - hsCyc - 1)});
                if (o_write_eop) begin
                    lastEopCyc = cyc;
                    eopCnt++;
                    if (eopCnt < expA.size()) expSrdyCyc = cyc + 1;
                end
            end
            if (o_operation_valid) begin
                if (opWait == 0) curOp = {o_operation_type, o_operation_addr, o_operation_num};
                else checkOutput("op_stable_while_stalled",
                                 {o_operation_type, o_operation_addr, o_operation_num}, curOp);
                checkOutput("s_ready_low_in_cmd", o_s_ready, 0);
            end
            if (o_done) begin
                doneCnt++;
                doneCyc = cyc;
                checkOutput("req_ready_at_done", o_req_ready, 1);
                checkOutput("busy_low_at_done", o_busy, 0);
                break;
            end

            i_req_valid = !o_req_ready && ($urandom_range(0, 1) == 1);
            i_req_addr = 24'($urandom);
            i_req_len = 16'($urandom);
            if (srcIdx < len && $urandom_range(0, 99) >= gapPct) begin
                i_s_valid = 1'b1;
                i_s_data = srcQ[srcIdx];
            end else begin
                i_s_valid = 1'b0;
                i_s_data = 8'($urandom);
            end
            i_operation_ready = o_operation_valid ? (opWait >= stall) : ($urandom_range(0, 1) == 1);
            if (o_operation_valid && i_operation_ready) begin
                ops.push_back(curOp);
                hsCyc = cyc;
                opWait = 0;
            end else if (o_operation_valid) begin
                opWait++;
            end
            if (o_s_ready && i_s_valid) begin
                srcIdx++;
                if (nextB < bounds.size() && srcIdx == bounds[nextB]) begin
                    expOpCyc = cyc + 1;
                    nextB++;
                end
            end
        end

        i_req_valid = 1'b0;
        i_s_valid = 1'b0;
        i_operation_ready = 1'b0;
        if (aborted) return;

        checkOutput("op_count", ops.size(), expA.size());
        for (int i = 0; i < ops.size() && i < expA.size(); i++)
            checkOutput($sformatf("op%0d", i), ops[i], {2'd1, 24'(expA[i]), 9'(expN[i])});
        checkOutput("beat_count", beats.size(), len);
        pos = 0;
        for (int i = 0; i < expN.size(); i++) begin
            for (int k = 0; k < expN[i]; k++) begin
                if (pos < beats.size())
                    checkOutput($sformatf("chunk%0d_beat%0d", i, k), beats[pos],
                                {srcQ[pos], k == 0, k == expN[i] - 1, 16'(k)});
                pos++;
            end
        end
        checkOutput("done_count", doneCnt, 1);
        checkOutput("done_cycle", doneCyc, (len == 0) ? tAcc + 1 : lastEopCyc + 1);
        @(negedge i_clk); cyc++;
        checkOutput("done_single_pulse", o_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        checkIdleOutputs("in_reset");
        i_rst = 1'b1;
        @(negedge i_clk);
        checkIdleOutputs("after_reset");

        applyStimulus(24'h000000, 256, 0, 0, -1);
        applyStimulus(24'h0000F0, 300, 30, 2, -1);
        applyStimulus(24'h123456, 1, 0, 1, -1);
        applyStimulus(24'h000310, 40, 40, 20, -1);
        applyStimulus(24'hFFFFF8, 16, 20, 3, -1);
        applyStimulus(24'h00ABCD, 0, 0, 0, -1);

        applyStimulus(24'h000400, 256, 10, 1, 100);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkIdleOutputs("after_mid_reset");
        applyStimulus(24'h000200, 4, 0, 0, -1);

        for (int t = 0; t < 3; t++)
            applyStimulus(24'($urandom), $urandom_range(1, 600), $urandom_range(0, 50),
                          $urandom_range(0, 4), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_page_packer.md
# flash_page_packer

Upstream feeder for `flash_driver` page programming. Accepts one write request (24-bit start address, 16-bit byte count) plus a byte stream, and splits the transfer into page-aligned chunks of at most 256 bytes. Each chunk is buffered locally, then issued to `flash_driver` as one program operation, with its bytes streamed back-to-back using `sop`/`eop`/`valid` framing. Sits between the user/host data source and `flash_driver`'s operation and write-data ports.

## Interface

Parameters:
- `P_PROGRAM_TYPE`, 2'd1, value driven on `o_operation_type` for every chunk
- `P_PAGE_SIZE`, 256, page size in bytes; fixed at 256, matching the `flash_driver` per-operation limit

Ports:
- `i_clk`  in  1  single clock
- `i_rst`  in  1  reset; **asynchronous, active-low**
- `i_req_addr`  in  24  start flash address
- `i_req_len`  in  16  total bytes, 0..65535
- `i_req_valid`  in  1  request valid
- `o_req_ready`  out  1  request ready; high only in IDLE
- `i_s_data`  in  8  source byte
- `i_s_valid`  in  1  source byte valid
- `o_s_ready`  out  1  source ready; high only in FILL
- `o_operation_type`  out  2  to `flash_driver`
- `o_operation_addr`  out  24  chunk start address
- `o_operation_num`  out  9  chunk length, 1..256
- `o_operation_valid`  out  1  operation handshake valid
- `i_operation_ready`  in  1  operation handshake ready
- `o_write_data`  out  8  chunk byte
- `o_write_sop`  out  1  first byte of chunk
- `o_write_eop`  out  1  last byte of chunk
- `o_write_valid`  out  1  byte valid
- `o_busy`  out  1  high whenever state is not IDLE
- `o_done`  out  1  one-cycle pulse when the request completes

## Operation

State machine:
- **IDLE**
  - `o_req_ready`=1.
  - On `i_req_valid`, latch `addr`=`i_req_addr` and `rem`=`i_req_len`.
  - If `i_req_len`==0: pulse `o_done` next cycle and stay in IDLE.
  - Otherwise go to FILL.
- **FILL**
  - On entry, `clen` = min(`rem`, 256 − `addr[7:0]`). Compute this in 17-bit arithmetic; the result is 1..256.
  - `o_s_ready`=1. Each `i_s_valid` beat writes `buf[idx]` and increments `idx`.
  - After beat `clen`−1 is accepted, drop `o_s_ready` and go to CMD.
- **CMD**
  - Assert `o_operation_valid` with `type`=`P_PROGRAM_TYPE`, `addr`=`addr`, `num`=`clen`.
  - Hold all fields stable until a cycle in which `valid` and `i_operation_ready` are both high, then go to SEND.
- **SEND**
  - Emit `buf[0..clen−1]` on consecutive cycles with `o_write_valid`=1.
  - `sop` marks byte 0 and `eop` marks byte `clen`−1; both are high together when `clen`=1.
  - After the last byte: `addr` += `clen` (24-bit, wraps modulo 2^24) and `rem` −= `clen`.
  - If `rem`==0: pulse `o_done` and return to IDLE. Otherwise go to FILL.

Rules:
- Buffer is 256×8; a synchronous-read RAM is acceptable.
- Only the first chunk can be shorter than 256 because of alignment. The last chunk can be shorter because of `rem`.
- `i_req_*` changes outside IDLE are ignored.
- Source bytes are never dropped. Backpressure is applied only through `o_s_ready`.

## Timing

- Reset values: all registered outputs 0 (`o_operation_*`, `o_write_*`, `o_busy`, `o_done`); state=IDLE, so `o_req_ready`=1 and `o_s_ready`=0.
- Request accepted in cycle T → `o_busy`=1 and `o_s_ready`=1 from T+1.
- Last FILL beat accepted in cycle F → `o_operation_valid`=1 from F+1.
- Operation handshake in cycle H → byte 0 (`sop`) is valid at H+1 and byte k at H+1+k, with no gaps.
- Last byte at cycle L → next chunk's `o_s_ready` at L+1, or `o_done`=1 at L+1 with `o_req_ready`=1 from L+1.
- `i_operation_ready` is not sampled outside CMD. Ready high during SEND or FILL has no effect.
- Asynchronous reset mid-operation: outputs clear immediately. No `eop` or `done` is emitted. Buffer contents are don't-care. The next request behaves normally.

## Test plan

1. `addr`=0x000000, `len`=256, source always valid → one operation (0x000000, num 256). 256 write beats follow the handshake with no gaps; `sop` on beat 0, `eop` on beat 255; one `done` pulse.
2. `addr`=0x0000F0, `len`=300 → three operations: (0x0000F0, 16), (0x000100, 256), (0x000200, 28). Each data burst is framed by exactly one `sop` and one `eop`; the byte sequence is preserved across chunks.
3. `addr`=0x123456, `len`=1 → one operation (0x123456, num 1); `sop`=`eop`=`valid`=1 in the same cycle; then `done`.
4. `i_operation_ready` held low for 20 cycles in CMD, with random `i_s_valid` gaps during FILL → operation fields and `valid` stay stable, `o_s_ready`=0 throughout CMD, and no data is lost.
5. `addr`=0xFFFFF8, `len`=16 → operations (0xFFFFF8, 8) then (0x000000, 8). Also `len`=0 → `done` pulse with no operation issued.
6. Reset asserted during SEND on byte 100 → all outputs 0 immediately. After release, a new request (0x000200, 4) completes correctly.
